// File: rtl/rom_arbiter.sv
// Two-requester arbiter serialising access to a shared combinational lookup ROM,
// with registered ROM address and read data. Define ROM_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              w_grant;
  logic              w_winner;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_rom_addr;

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic              r_prio;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          w_state_nxt = ACCESS;
          if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            w_winner = 1'b0;
`else
            w_winner = r_prio;
`endif
          end else begin
            w_winner = req1;
          end
        end
      end
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_rdata    <= '0;
      r_rom_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner    <= w_winner;
        r_rom_addr <= w_winner ? addr1 : addr0;
      end
      // ROM output settles from the address registered at the grant edge
      if (r_state == ACCESS) begin
        r_rdata <= rom_data;
      end
    end
  end

`ifndef ROM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (r_state == DONE) begin
      r_prio <= ~r_owner;
    end
  end
`endif

  // Handshake outputs decode straight from registered state, so they carry no combinational input paths
  assign gnt0     = (r_state != IDLE) && !r_owner;
  assign gnt1     = (r_state != IDLE) &&  r_owner;
  assign rvalid0  = (r_state == DONE) && !r_owner;
  assign rvalid1  = (r_state == DONE) &&  r_owner;
  assign rdata    = r_rdata;
  assign rom_addr = r_rom_addr;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single combinational lookup ROM (8-bit address, 4-bit data) between two requesters. It serialises accesses with a req/gnt/rvalid handshake and registers the ROM address. It captures the ROM output into a registered read-data bus, so neither requester sees combinational ROM paths. It sits between the ROM instance and the sequential logic that consumes table values.

## Interface
- ADDR_W, 8, address width; matches the ROM address port
- DATA_W, 4, data width; matches the ROM data port

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 access request; held high until rvalid0
- addr0  input  ADDR_W  requester 0 address; stable while req0 is high
- req1  input  1  requester 1 access request; held high until rvalid1
- addr1  input  ADDR_W  requester 1 address; stable while req1 is high
- gnt0  output  1  requester 0 owns the ROM (ACCESS and DONE states)
- gnt1  output  1  requester 1 owns the ROM (ACCESS and DONE states)
- rvalid0  output  1  one-cycle pulse: rdata is valid for requester 0
- rvalid1  output  1  one-cycle pulse: rdata is valid for requester 1
- rdata  output  DATA_W  registered ROM data, shared by both requesters
- rom_addr  output  ADDR_W  registered address driven to the ROM
- rom_data  input  DATA_W  combinational ROM output

## Operation
- FSM states are IDLE, ACCESS and DONE, all registered.
- **IDLE**
  - No request: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the requester selected by the priority pointer `prio`.
  - On grant: latch the winner's address into rom_addr, set that gnt, record the owner, go to ACCESS.
- **ACCESS**
  - Capture rom_data into rdata.
  - Assert the owner's rvalid for the next cycle.
  - Go to DONE.
- **DONE**
  - rvalid of the owner is high for exactly this cycle.
  - Next state is IDLE.
  - Clear gnt.
  - Set `prio` to the non-owner.
- Requests are evaluated only in IDLE. A req edge in ACCESS or DONE is ignored until IDLE.
- A requester that keeps req high after rvalid is treated as a new request at the next IDLE.
- Addresses are passed to the ROM unmodified. Addresses above 7 return the ROM default of 0; the arbiter does no range check.
- rdata holds its last captured value until the next ACCESS.
- rom_addr holds its last granted address while in IDLE.
- gnt0 and gnt1 are never both high; rvalid0 and rvalid1 are never both high.

## Timing
- Reset values:
  - state=IDLE, prio=requester 0
  - gnt0=gnt1=0, rvalid0=rvalid1=0
  - rdata=0, rom_addr=0
- Reset applied mid-transaction aborts it: no rvalid is produced, and all outputs take their reset values at the next edge.
- Latency:
  - Edge E0: IDLE samples req. gnt and rom_addr are valid after E0.
  - Edge E1: rdata is captured. rvalid is high from E1 to E2.
  - Edge E2: return to IDLE.
  - Next grant earliest at E3, so one access every 3 cycles.
- Simultaneous req0 and req1 in IDLE: `prio` decides. Under continuous contention the requesters alternate (0,1,0,1…).
- A requester may drop req in the cycle after its rvalid. If it has not dropped req by that cycle, it is re-served.

## Configuration
- Macro `ROM_ARB_FIXED_PRIO_EN`
- **Defined:** fixed priority. req0 always wins a simultaneous request, and the `prio` register is not implemented.
- **Undefined (default):** round-robin via `prio` as described above.

## Test plan
- Reset, then req0=1 with addr0=3 → gnt0 high after E0, rom_addr=3; rdata=6 and rvalid0 a single pulse at E1; IDLE at E2; gnt1 and rvalid1 stay 0.
- req0 with addr0=5 and req1 with addr1=7, asserted together and held → serve order 0,1,0. rdata=10 with rvalid0, then 14 with rvalid1, then 10. Each access 3 cycles apart.
- Same stimulus with `ROM_ARB_FIXED_PRIO_EN` defined → requester 0 is served repeatedly; rvalid1 never pulses while req0 is held.
- req1 with addr1=200 → rdata=0, rvalid1 pulses once.
- Grant to requester 0 with addr0=2, rst asserted in ACCESS → no rvalid0; all outputs 0 next cycle. A later req1 with addr1=4 is served normally with rdata=8.
- req1 asserted during requester 0's ACCESS → ignored until IDLE; granted at the first IDLE edge after DONE.
